// File: rtl/booth_mac_pipe.sv
// Pipelined radix-4 Booth multiply-accumulate with selectable rounding and saturation.
// A single advance signal stalls every stage together; bubbles flow through untouched.
module booth_mac_pipe #(
    parameter int W   = 24,
    parameter int F   = 22,
    parameter int GPS = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   rnd_mode,
    input  logic         acc_en,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] p,
    output logic         ovf
);
    localparam int G  = W / 2;
    localparam int S  = (G + GPS - 1) / GPS;
    localparam int PW = 2 * W;
    localparam logic [F-1:0] HALF = F'(1) << (F - 1);
    localparam logic signed [PW+1:0] MAXV = {{(W + 3){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [PW+1:0] MINV = {{(W + 3){1'b1}}, {(W - 1){1'b0}}};

    // Booth digit for group g is taken from a[2g+1:2g-1] with an implicit zero below the LSB.
    function automatic logic signed [PW-1:0] booth_pp(input logic [W-1:0] av,
                                                      input logic [W-1:0] bv,
                                                      input int g);
        logic [W:0]            ax;
        logic [2:0]            trip;
        logic signed [PW-1:0]  bx;
        logic signed [PW-1:0]  pp;
        int                    gg;
        gg   = (g < G) ? g : G - 1;
        ax   = {av, 1'b0};
        trip = ax[2*gg +: 3];
        bx   = {{W{bv[W-1]}}, bv};
        case (trip)
            3'b001, 3'b010: pp = bx;
            3'b011:         pp = bx <<< 1;
            3'b100:         pp = -(bx <<< 1);
            3'b101, 3'b110: pp = -bx;
            default:        pp = '0;
        endcase
        return pp <<< (2 * gg);
    endfunction

    logic                 w_adv;
    logic                 r_vld     [0:S];
    logic [1:0]           r_mode    [0:S];
    logic                 r_acc_en  [0:S];
    logic                 r_acc_clr [0:S];
    logic [W-1:0]         r_a       [0:S-1];
    logic [W-1:0]         r_b       [0:S-1];
    logic signed [PW-1:0] r_sum     [1:S];
    logic                 r_out_valid;
    logic [W-1:0]         r_p;
    logic                 r_ovf;
    logic [W-1:0]         r_acc;

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign p         = r_p;
    assign ovf       = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld[0] <= 1'b0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_a[0]       <= a;
            r_b[0]       <= b;
            r_mode[0]    <= rnd_mode;
            r_acc_en[0]  <= acc_en;
            r_acc_clr[0] <= acc_clr;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= S; gi++) begin : g_stage
            logic signed [PW-1:0] w_in_sum;
            logic signed [PW-1:0] w_out_sum;

            if (gi == 1) begin : g_first
                assign w_in_sum = '0;
            end else begin : g_chain
                assign w_in_sum = r_sum[gi-1];
            end

            always_comb begin
                w_out_sum = w_in_sum;
                for (int j = 0; j < GPS; j++) begin
                    if ((gi - 1) * GPS + j < G) begin
                        w_out_sum = w_out_sum + booth_pp(r_a[gi-1], r_b[gi-1], (gi - 1) * GPS + j);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld[gi] <= 1'b0;
                end else if (w_adv) begin
                    r_vld[gi] <= r_vld[gi-1];
                end
            end

            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_sum[gi]     <= w_out_sum;
                    r_mode[gi]    <= r_mode[gi-1];
                    r_acc_en[gi]  <= r_acc_en[gi-1];
                    r_acc_clr[gi] <= r_acc_clr[gi-1];
                end
            end

            // Operands only need to travel as far as the last adder stage.
            if (gi < S) begin : g_fwd
                always_ff @(posedge clk) begin
                    if (w_adv) begin
                        r_a[gi] <= r_a[gi-1];
                        r_b[gi] <= r_b[gi-1];
                    end
                end
            end
        end
    endgenerate

    logic signed [PW:0]   w_pe;
    logic signed [PW:0]   w_q;
    logic [F-1:0]         w_rem;
    logic                 w_inc;
    logic signed [PW+1:0] w_rx;
    logic signed [PW+1:0] w_base;
    logic signed [PW+1:0] w_sum;
    logic signed [PW+1:0] w_val;
    logic                 w_prod_ovf;
    logic                 w_sum_ovf;
    logic                 w_ovf;
    logic [W-1:0]         w_p;

    always_comb begin
        w_pe  = {r_sum[S][PW-1], r_sum[S]};
        w_q   = w_pe >>> F;
        w_rem = r_sum[S][F-1:0];
        w_inc = 1'b0;
        case (r_mode[S])
            2'd1:    w_inc = (w_rem >= HALF);
            2'd2:    w_inc = (w_rem > HALF) || ((w_rem == HALF) && w_q[0]);
            default: w_inc = 1'b0;
        endcase
        w_rx       = {w_q[PW], w_q} + {{(PW + 1){1'b0}}, w_inc};
        w_base     = (r_acc_en[S] && !r_acc_clr[S]) ? {{(W + 2){r_acc[W-1]}}, r_acc} : '0;
        w_sum      = w_rx + w_base;
        w_prod_ovf = (w_rx > MAXV) || (w_rx < MINV);
        w_sum_ovf  = (w_sum > MAXV) || (w_sum < MINV);
        w_val      = r_acc_en[S] ? w_sum : w_rx;
        w_ovf      = w_prod_ovf || (r_acc_en[S] && w_sum_ovf);
        if (w_val > MAXV) begin
            w_p = MAXV[W-1:0];
        end else if (w_val < MINV) begin
            w_p = MINV[W-1:0];
        end else begin
            w_p = w_val[W-1:0];
        end
    end

    // Accumulator and output register share one edge so consecutive accumulates chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_p         <= '0;
            r_ovf       <= 1'b0;
            r_acc       <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_vld[S];
            if (r_vld[S]) begin
                r_p   <= w_p;
                r_ovf <= w_ovf;
                if (r_acc_en[S]) begin
                    r_acc <= w_p;
                end
            end
        end
    end
endmodule

// File: tb/tb_booth_mac_pipe.sv
// Scoreboard bench for booth_mac_pipe (W=24, Q2.22): the driver queues expected results,
// a monitor pops and compares on every output handshake.
module tb_booth_mac_pipe;
    localparam int W = 24;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic [1:0]   rnd_mode  = 2'd0;
    logic         acc_en    = 1'b0;
    logic         acc_clr   = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] p;
    logic         ovf;

    booth_mac_pipe #(.W(24), .F(22), .GPS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rnd_mode  (rnd_mode),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] p;
        logic         ovf;
        int           acc_cyc;
        bit           chk_lat;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    bit           prev_stall = 1'b0;
    logic [W-1:0] hold_p;
    logic         hold_ovf;
    exp_t         mon_e;

    // b = 0x200000 is 0.5, so these products land exactly on or near a half LSB.
    logic [W-1:0] rnd_a   [0:2]      = '{24'h000001, 24'h000003, 24'hFFFFFF};
    logic [W-1:0] rnd_exp [0:2][0:2] = '{'{24'h000000, 24'h000001, 24'h000000},
                                         '{24'h000001, 24'h000002, 24'h000002},
                                         '{24'hFFFFFF, 24'h000000, 24'h000000}};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] tm,
                        input logic te, input logic tc, input logic [W-1:0] ep, input logic eo,
                        input bit lat, input string nm);
        exp_t e;
        int   tries;
        bit   done;
        tries = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            a        = ta;
            b        = tb;
            rnd_mode = tm;
            acc_en   = te;
            acc_clr  = tc;
            in_valid = 1'b1;
            #1;
            if (in_ready) begin
                e.p       = ep;
                e.ovf     = eo;
                e.acc_cyc = cyc;
                e.chk_lat = lat;
                e.name    = nm;
                sb.push_back(e);
                done = 1'b1;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end else begin
                tries++;
                if (tries > 200) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL %s_accept: in_ready stayed 0, expected acceptance", nm);
                    in_valid = 1'b0;
                    done     = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_drain(input string nm);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check({nm, "_drain"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold", 32'({out_valid, ovf, p}), 32'({1'b1, hold_ovf, hold_p}));
            end
            if (out_valid && !out_ready) begin
                check("in_ready_stall", 32'(in_ready), 32'd0);
                prev_stall = 1'b1;
                hold_p     = p;
                hold_ovf   = ovf;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_out: got p=0x%06h, expected no output", p);
                end else begin
                    mon_e = sb.pop_front();
                    $display("[TB] %s p=0x%06h ovf=%0d (want 0x%06h/%0d)", mon_e.name, p, ovf,
                             mon_e.p, mon_e.ovf);
                    check(mon_e.name, 32'({p, ovf}), 32'({mon_e.p, mon_e.ovf}));
                    if (mon_e.chk_lat) begin
                        check({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc_cyc), 32'd8);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nv;
        logic [W-1:0] ta;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_p", 32'(p), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0x100000 is 0.25 in Q2.22: 0.25 * 0.25 = 0.0625 = 0x040000.
        send(24'h100000, 24'h100000, 2'd0, 1'b0, 1'b0, 24'h040000, 1'b0, 1'b1, "basic");
        wait_drain("basic");

        send(24'h7FFFFF, 24'h7FFFFF, 2'd0, 1'b0, 1'b0, 24'h7FFFFF, 1'b1, 1'b0, "sat_max_max");
        send(24'h800000, 24'h7FFFFF, 2'd0, 1'b0, 1'b0, 24'h800000, 1'b1, 1'b0, "sat_min_max");
        send(24'h800000, 24'h800000, 2'd0, 1'b0, 1'b0, 24'h7FFFFF, 1'b1, 1'b0, "sat_min_min");
        send(24'hC00000, 24'hC00000, 2'd0, 1'b0, 1'b0, 24'h400000, 1'b0, 1'b0, "neg_x_neg");
        send(24'hC00000, 24'h7FFFFF, 2'd0, 1'b0, 1'b0, 24'h800001, 1'b0, 1'b0, "near_min");
        for (int i = 0; i < 3; i++) begin
            for (int m = 0; m < 3; m++) begin
                send(rnd_a[i], 24'h200000, 2'(m), 1'b0, 1'b0, rnd_exp[i][m], 1'b0, 1'b0,
                     $sformatf("rnd_a%0d_m%0d", i, m));
            end
        end
        send(24'h000003, 24'h200000, 2'd3, 1'b0, 1'b0, 24'h000001, 1'b0, 1'b0, "rnd_mode3");
        wait_drain("vectors");

        // Ten back-to-back operands times +1.0 / -1.0 with a six-cycle output stall.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    ta = W'(24'h012345 + i * 24'h011111);
                    if (i % 2 == 0) begin
                        send(ta, 24'h400000, 2'd0, 1'b0, 1'b0, ta, 1'b0, 1'b0, $sformatf("bp%0d", i));
                    end else begin
                        send(ta, 24'hC00000, 2'd0, 1'b0, 1'b0, W'(-ta), 1'b0, 1'b0, $sformatf("bp%0d", i));
                    end
                end
            end
            begin
                repeat (9) @(negedge clk);
                out_ready = 1'b0;
                repeat (6) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain("backpressure");

        // 0x100000 * 0x200000 = 0.25 * 0.5 = 0x080000 per step.
        send(24'h100000, 24'h200000, 2'd0, 1'b1, 1'b1, 24'h080000, 1'b0, 1'b0, "acc1");
        send(24'h100000, 24'h200000, 2'd0, 1'b1, 1'b0, 24'h100000, 1'b0, 1'b0, "acc2");
        send(24'h100000, 24'h200000, 2'd0, 1'b1, 1'b0, 24'h180000, 1'b0, 1'b0, "acc3");
        send(24'h100000, 24'h200000, 2'd0, 1'b1, 1'b0, 24'h200000, 1'b0, 1'b0, "acc4");
        send(24'h100000, 24'h200000, 2'd0, 1'b0, 1'b1, 24'h080000, 1'b0, 1'b0, "acc_off");
        send(24'h100000, 24'h200000, 2'd0, 1'b1, 1'b0, 24'h280000, 1'b0, 1'b0, "acc5");
        send(24'h7FFFFF, 24'h7FFFFF, 2'd0, 1'b1, 1'b1, 24'h7FFFFF, 1'b1, 1'b0, "acc_sat_prod");
        send(24'h400000, 24'h400000, 2'd0, 1'b1, 1'b0, 24'h7FFFFF, 1'b1, 1'b0, "acc_sat_sum");
        wait_drain("accumulate");

        // Stall the output so one result waits and five more sit in the pipe, then reset.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(24'h100000, 24'h200000, 2'd0, 1'b0, 1'b0, 24'h080000, 1'b0, 1'b0, $sformatf("flight%0d", i));
        end
        repeat (5) @(negedge clk);
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_p", 32'(p), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            #3;
            if (out_valid) nv++;
        end
        check("no_stale", 32'(nv), 32'd0);

        // acc_reg was cleared by reset, so an accumulate without clear yields the bare product.
        send(24'h100000, 24'h200000, 2'd0, 1'b1, 1'b0, 24'h080000, 1'b0, 1'b1, "post_rst_acc");
        wait_drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
